// File: rtl/lib_cpu.sv
// lib_cpu: opecode enumeration and nibble table shared by the CPU decoder and the program loader.
package lib_cpu;
  typedef enum logic [3:0] {
    ADD_A_IMM, MOV_A_B, IN_A, MOV_A_IMM, MOV_B_A, ADD_B_IMM,
    IN_B, MOV_B_IMM, OUT_B, OUT_IMM, JNC_IMM, JMP_IMM, INVALID
  } OPECODE;
  localparam logic [3:0] NIB_ADD_A_IMM = 4'b0000;
  localparam logic [3:0] NIB_MOV_A_B   = 4'b0001;
  localparam logic [3:0] NIB_IN_A      = 4'b0010;
  localparam logic [3:0] NIB_MOV_A_IMM = 4'b0011;
  localparam logic [3:0] NIB_MOV_B_A   = 4'b0100;
  localparam logic [3:0] NIB_ADD_B_IMM = 4'b0101;
  localparam logic [3:0] NIB_IN_B      = 4'b0110;
  localparam logic [3:0] NIB_MOV_B_IMM = 4'b0111;
  localparam logic [3:0] NIB_OUT_B     = 4'b1001;
  localparam logic [3:0] NIB_OUT_IMM   = 4'b1011;
  localparam logic [3:0] NIB_JNC_IMM   = 4'b1110;
  localparam logic [3:0] NIB_JMP_IMM   = 4'b1111;
  // returns {invalid, nibble}
  function automatic logic [4:0] encode_opecode(input OPECODE op);
    case (op)
      ADD_A_IMM: return {1'b0, NIB_ADD_A_IMM};
      MOV_A_B:   return {1'b0, NIB_MOV_A_B};
      IN_A:      return {1'b0, NIB_IN_A};
      MOV_A_IMM: return {1'b0, NIB_MOV_A_IMM};
      MOV_B_A:   return {1'b0, NIB_MOV_B_A};
      ADD_B_IMM: return {1'b0, NIB_ADD_B_IMM};
      IN_B:      return {1'b0, NIB_IN_B};
      MOV_B_IMM: return {1'b0, NIB_MOV_B_IMM};
      OUT_B:     return {1'b0, NIB_OUT_B};
      OUT_IMM:   return {1'b0, NIB_OUT_IMM};
      JNC_IMM:   return {1'b0, NIB_JNC_IMM};
      JMP_IMM:   return {1'b0, NIB_JMP_IMM};
      default:   return 5'b1_0000;
    endcase
  endfunction
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: instruction stream, program memory bus and load status of the program loader.
interface program_loader_if import lib_cpu::*; #(parameter int ADDR_W = 4);
  logic start, in_valid, in_ready, in_last, mem_we, done, error, cpu_hold;
  OPECODE in_opecode;
  logic [3:0] in_imm;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [ADDR_W:0] count;
  modport master (
    input start, in_valid, in_opecode, in_imm, in_last, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata, count, done, error, cpu_hold
  );
  modport slave (
    output start, in_valid, in_opecode, in_imm, in_last, mem_rdata,
    input in_ready, mem_we, mem_addr, mem_wdata, count, done, error, cpu_hold
  );
endinterface

// File: rtl/program_loader_encoder.sv
// instruction_encoder: combinational opecode+imm to machine byte, flags INVALID opecodes.
module instruction_encoder import lib_cpu::*; (
  input  OPECODE     opecode,
  input  logic [3:0] imm,
  output logic [7:0] code,
  output logic       invalid
);
  logic [4:0] e;
  assign e = encode_opecode(opecode);
  assign code = {e[3:0], imm};
  assign invalid = e[4];
endmodule

// File: rtl/program_loader.sv
// program_loader: writes encoded instructions to program memory, holding the CPU until done.
// Read-back verification is enabled by defining PROGRAM_LOADER_VERIFY_EN.
module program_loader import lib_cpu::*; #(parameter int ADDR_W = 4) (
  input logic clk,
  input logic rst,
  program_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, CHECK, DONE, ERROR} state_t;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  state_t state;
  logic last_q, invalid, fin;
  logic [7:0] code;
  logic [ADDR_W:0] cnt_n;
  instruction_encoder u_enc (.opecode(bus.in_opecode), .imm(bus.in_imm), .code(code), .invalid(invalid));
  assign bus.in_ready = state == LOAD;
  assign cnt_n = bus.count + 1'b1;
  assign fin = last_q || cnt_n == DEPTH;
`ifndef PROGRAM_LOADER_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^bus.mem_rdata;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_q <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.count <= '0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      bus.cpu_hold <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (bus.start) begin
          state <= LOAD;
          bus.count <= '0;
          bus.mem_addr <= '0;
          bus.done <= 1'b0;
          bus.error <= 1'b0;
          bus.cpu_hold <= 1'b1;
        end
        LOAD: if (bus.in_valid) begin
          if (invalid) begin
            state <= ERROR;
            bus.error <= 1'b1;
          end else begin
            state <= WRITE;
            bus.mem_wdata <= code;
            bus.mem_we <= 1'b1;
            last_q <= bus.in_last;
          end
        end
`ifdef PROGRAM_LOADER_VERIFY_EN
        WRITE: begin
          bus.mem_we <= 1'b0;
          state <= VERIFY;
        end
        VERIFY: state <= CHECK;
        CHECK: if (bus.mem_rdata == bus.mem_wdata) begin
          state <= fin ? DONE : LOAD;
          bus.count <= cnt_n;
          bus.mem_addr <= bus.mem_addr + 1'b1;
          bus.done <= fin;
          bus.cpu_hold <= !fin;
        end else begin
          state <= ERROR;
          bus.error <= 1'b1;
        end
`else
        WRITE: begin
          bus.mem_we <= 1'b0;
          state <= fin ? DONE : LOAD;
          bus.count <= cnt_n;
          bus.mem_addr <= bus.mem_addr + 1'b1;
          bus.done <= fin;
          bus.cpu_hold <= !fin;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random and directed loads checked against a program-level reference model.
module tb_program_loader;
  import lib_cpu::*;
`ifdef PROGRAM_LOADER_VERIFY_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst = 1'b1, corrupt = 1'b0;
  int vectors = 0, miscompares = 0, nwrites = 0;
  logic [7:0] mem [16];
  logic [7:0] exp_mem [16];
  logic [7:0] rdata_q;
  logic [3:0] nib [12];
  OPECODE prog_op [$];
  logic [3:0] prog_imm [$];
  bit prog_last [$];
  program_loader_if #(.ADDR_W(4)) bus ();
  program_loader #(.ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      nwrites <= nwrites + 1;
    end
    rdata_q <= corrupt ? 8'h00 : mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, " mem_we"}, 32'(bus.mem_we), 0);
    chk({tag, " mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, " mem_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, " count"}, 32'(bus.count), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " error"}, 32'(bus.error), 0);
    chk({tag, " cpu_hold"}, 32'(bus.cpu_hold), 1);
  endtask

  task automatic gen(input int n, input bit use_last, input int bad);
    prog_op.delete(); prog_imm.delete(); prog_last.delete();
    for (int i = 0; i < n; i++) begin
      prog_op.push_back(i == bad ? INVALID : OPECODE'(4'($urandom_range(0, 11))));
      prog_imm.push_back(4'($urandom));
      prog_last.push_back(use_last && i == n - 1);
    end
  endtask

  task automatic add(input OPECODE op, input logic [3:0] imm, input bit last);
    prog_op.push_back(op); prog_imm.push_back(imm); prog_last.push_back(last);
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk) #1 bus.start = 1'b0;
  endtask

  task automatic drive(input int i, output bit ok);
    int k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 20) begin @(negedge clk); k++; end
    ok = bus.in_ready;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_opecode = prog_op[i];
    bus.in_imm = prog_imm[i];
    bus.in_last = prog_last[i];
    @(posedge clk) #1 bus.in_valid = 1'b0;
  endtask

  task automatic run_load(input string tag);
    int cnt = 0, nd = 0, w0, k;
    bit exp_err = 0, exp_done = 0, ok;
    for (int i = 0; i < prog_op.size(); i++) begin
      nd = i + 1;
      if (prog_op[i] == INVALID) begin exp_err = 1; break; end
      cnt++;
      if (prog_last[i] || cnt == 16) begin exp_done = 1; break; end
    end
    pulse_start();
    chk({tag, " start done"}, 32'(bus.done), 0);
    chk({tag, " start error"}, 32'(bus.error), 0);
    chk({tag, " start count"}, 32'(bus.count), 0);
    w0 = nwrites;
    for (int i = 0; i < nd; i++) begin
      drive(i, ok);
      chk({tag, " ready seen"}, 32'(ok), 1);
      if (!ok) return;
      if (prog_op[i] == INVALID) begin
        chk({tag, " invalid no we"}, 32'(bus.mem_we), 0);
        chk({tag, " invalid error"}, 32'(bus.error), 1);
      end else begin
        exp_mem[i] = {nib[int'(prog_op[i])], prog_imm[i]};
        chk({tag, " we"}, 32'(bus.mem_we), 1);
        chk({tag, " addr"}, 32'(bus.mem_addr), 32'(i));
        chk({tag, " wdata"}, 32'(bus.mem_wdata), 32'(exp_mem[i]));
      end
    end
    k = 0;
    while (!(bus.done || bus.error) && k < 20) begin @(posedge clk) #1; k++; end
    if (exp_done) chk({tag, " done latency"}, 32'(k), 32'(LAT));
    chk({tag, " count"}, 32'(bus.count), 32'(cnt));
    chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(cnt % 16));
    chk({tag, " done"}, 32'(bus.done), 32'(exp_done));
    chk({tag, " error"}, 32'(bus.error), 32'(exp_err));
    chk({tag, " cpu_hold"}, 32'(bus.cpu_hold), 32'(!exp_done));
    chk({tag, " in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, " writes"}, 32'(nwrites - w0), 32'(cnt));
    for (int a = 0; a < 16; a++) chk({tag, " mem"}, {24'h0, mem[a]}, {24'h0, exp_mem[a]});
  endtask

  initial begin
    bit ok;
    int w0;
    nib = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hE, 4'hF};
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_opecode = ADD_A_IMM; bus.in_imm = '0; bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst = 1'b0;
    prog_op.delete(); prog_imm.delete(); prog_last.delete();
    add(MOV_A_IMM, 4'd5, 1);
    run_load("single");
    chk("single byte", {24'h0, mem[0]}, 32'h35);
    prog_op.delete(); prog_imm.delete(); prog_last.delete();
    add(JMP_IMM, 4'd3, 0); add(OUT_B, 4'd0, 0); add(ADD_A_IMM, 4'd1, 1);
    run_load("three");
    chk("three byte0", {24'h0, mem[0]}, 32'hF3);
    chk("three byte1", {24'h0, mem[1]}, 32'h90);
    chk("three byte2", {24'h0, mem[2]}, 32'h01);
    gen(16, 0, -1);
    run_load("full");
    w0 = nwrites;
    @(negedge clk) bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full idle ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    chk("full idle writes", 32'(nwrites - w0), 0);
    gen(3, 1, 1);
    run_load("invalid");
    gen(2, 1, -1);
    run_load("after error");
    for (int t = 0; t < 12; t++) begin
      int n = $urandom_range(1, 16);
      int bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      gen(n, n < 16 ? 1'b1 : 1'($urandom), bad);
      run_load($sformatf("rand%0d", t));
    end
`ifdef PROGRAM_LOADER_VERIFY_EN
    prog_op.delete(); prog_imm.delete(); prog_last.delete();
    add(MOV_A_IMM, 4'd5, 1);
    corrupt = 1'b1;
    pulse_start();
    drive(0, ok);
    chk("verify ready seen", 32'(ok), 1);
    repeat (4) @(posedge clk);
    #1 chk("verify error", 32'(bus.error), 1);
    chk("verify count", 32'(bus.count), 0);
    chk("verify done", 32'(bus.done), 0);
    corrupt = 1'b0;
`endif
    gen(3, 1, -1);
    pulse_start();
    drive(0, ok);
    chk("rst ready seen", 32'(ok), 1);
    chk("rst in write", 32'(bus.mem_we), 1);
    rst = 1'b1;
    #1 chk_reset("rst async");
    w0 = nwrites;
    repeat (3) @(posedge clk);
    #1 chk("rst no writes", 32'(nwrites - w0), 0);
    chk_reset("rst held");
    @(negedge clk) rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
